// File: rtl/fcu_credit_ctrl_if.sv
// Bus between the switch allocator and the credit-based flow-control unit.
// Groups the request, grant, credit-return and status signals of all output ports.
interface fcu_credit_ctrl_if #(
  parameter int NUM_PORTS = 5,
  parameter int ADDR_W    = 3,
  parameter int CNT_W     = 3
);
  // No valid/ready pairing on this bus: every signal is a per-port level that
  // is sampled on each rising edge. A grant is accepted (consumes a credit and
  // raises valid_o one cycle later) only when the registered credit count of
  // that output is nonzero. A credit_en pulse is one returned slot.
  logic [NUM_PORTS-1:0]        req_valid_i;
  logic [NUM_PORTS*ADDR_W-1:0] req_port_addr_i;
  logic [NUM_PORTS-1:0]        granted_i;
  logic [NUM_PORTS-1:0]        credit_en_i;
  logic [NUM_PORTS-1:0]        grant_access_o;
  logic [NUM_PORTS-1:0]        valid_o;
  logic [NUM_PORTS*CNT_W-1:0]  credit_cnt_o;
  logic [NUM_PORTS-1:0]        credit_err_o;

  modport master (
    output req_valid_i, req_port_addr_i, granted_i, credit_en_i,
    input  grant_access_o, valid_o, credit_cnt_o, credit_err_o
  );

  modport slave (
    input  req_valid_i, req_port_addr_i, granted_i, credit_en_i,
    output grant_access_o, valid_o, credit_cnt_o, credit_err_o
  );
endinterface

// File: rtl/fcu_credit_ctrl.sv
// Credit-based flow control for the router output side: one saturating credit
// counter per output, grant qualification, registered flit-valid, sticky errors.
module fcu_credit_ctrl #(
  parameter int  NUM_PORTS = 5,
  parameter int  BUF_DEPTH = 4,
  parameter int  ADDR_W    = 3,
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input logic              clk,
  input logic              rst,
  fcu_credit_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUF_DEPTH);

  logic [NUM_PORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]            valid_q, valid_d;
  logic [NUM_PORTS-1:0]            err_q, err_d;
  logic [NUM_PORTS-1:0]            req;
  logic [NUM_PORTS-1:0]            consume;
  logic [ADDR_W-1:0]               addr_f;

  // Addresses at or above NUM_PORTS never match a port index and drop out here.
  always_comb begin
    req    = '0;
    addr_f = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      addr_f = bus.req_port_addr_i[i*ADDR_W +: ADDR_W];
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bus.req_valid_i[i] && (32'(addr_f) == 32'(p))) begin
          req[p] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    err_d   = err_q;
    consume = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      consume[p] = bus.granted_i[p] && (cnt_q[p] != '0);
      if (bus.granted_i[p] && (cnt_q[p] == '0)) begin
        err_d[p] = 1'b1;
      end
      if (consume[p] && !bus.credit_en_i[p]) begin
        cnt_d[p] = cnt_q[p] - CNT_W'(1);
      end else if (bus.credit_en_i[p] && !consume[p]) begin
        // A return into a full counter is a downstream protocol error; hold.
        if (cnt_q[p] == CNT_MAX) begin
          err_d[p] = 1'b1;
        end else begin
          cnt_d[p] = cnt_q[p] + CNT_W'(1);
        end
      end
    end
    valid_d = consume;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= {NUM_PORTS{CNT_MAX}};
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.grant_access_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.grant_access_o[p] = req[p] && (cnt_q[p] != '0);
    end
  end

  assign bus.valid_o      = valid_q;
  assign bus.credit_cnt_o = cnt_q;
  assign bus.credit_err_o = err_q;
endmodule

// File: tb/tb_fcu_credit_ctrl.sv
// Bench for fcu_credit_ctrl: default 5-port/depth-4 instance checked against a
// credit model with a valid_o expectation queue, plus an 8-port/depth-8 instance.
module tb_fcu_credit_ctrl;
  localparam int NP = 5;
  localparam int BD = 4;
  localparam int AW = 3;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fcu_credit_ctrl_if #(.NUM_PORTS(NP), .ADDR_W(AW), .CNT_W(CW)) a_if ();
  fcu_credit_ctrl_if #(.NUM_PORTS(8),  .ADDR_W(3),  .CNT_W(4))  b_if ();

  fcu_credit_ctrl #(.NUM_PORTS(NP), .BUF_DEPTH(BD), .ADDR_W(AW)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  fcu_credit_ctrl #(.NUM_PORTS(8), .BUF_DEPTH(8), .ADDR_W(3)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int            exp_cnt[NP];
  logic [NP-1:0] exp_err;
  logic [NP-1:0] exp_req;
  logic [NP-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) exp_cnt[p] = BD;
    exp_err = '0;
    exp_q.delete();
  endtask

  function automatic logic [NP*CW-1:0] exp_cnt_vec();
    logic [NP*CW-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) v[p*CW +: CW] = CW'(exp_cnt[p]);
    return v;
  endfunction

  function automatic logic [NP-1:0] exp_ga();
    logic [NP-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) v[p] = exp_req[p] && (exp_cnt[p] != 0);
    return v;
  endfunction

  task automatic set_req(input logic [NP-1:0] v, input logic [NP*AW-1:0] a);
    logic [AW-1:0] f;
    a_if.req_valid_i     = v;
    a_if.req_port_addr_i = a;
    exp_req = '0;
    for (int i = 0; i < NP; i++) begin
      f = a[i*AW +: AW];
      if (v[i] && (int'(f) < NP)) exp_req[f] = 1'b1;
    end
  endtask

  // Drive one cycle of grants/returns, update the model, check after the edge.
  task automatic step(input logic [NP-1:0] g, input logic [NP-1:0] r);
    logic [NP-1:0] ev;
    logic [NP-1:0] got;
    logic          cons;
    a_if.granted_i   = g;
    a_if.credit_en_i = r;
    #1;
    chk("grant_access", 64'(a_if.grant_access_o), 64'(exp_ga()));
    ev = '0;
    for (int p = 0; p < NP; p++) begin
      cons = g[p] && (exp_cnt[p] != 0);
      if (g[p] && (exp_cnt[p] == 0)) exp_err[p] = 1'b1;
      if (cons && !r[p]) exp_cnt[p] = exp_cnt[p] - 1;
      else if (r[p] && !cons) begin
        if (exp_cnt[p] == BD) exp_err[p] = 1'b1;
        else exp_cnt[p] = exp_cnt[p] + 1;
      end
      ev[p] = cons;
    end
    exp_q.push_back(ev);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("valid_o", 64'(a_if.valid_o), 64'(got));
    chk("credit_cnt", 64'(a_if.credit_cnt_o), 64'(exp_cnt_vec()));
    chk("credit_err", 64'(a_if.credit_err_o), 64'(exp_err));
  endtask

  initial begin
    logic [31:0] b_exp;
    a_if.req_valid_i = '0; a_if.req_port_addr_i = '0;
    a_if.granted_i   = '0; a_if.credit_en_i     = '0;
    b_if.req_valid_i = '0; b_if.req_port_addr_i = '0;
    b_if.granted_i   = '0; b_if.credit_en_i     = '0;
    model_reset();
    exp_req = '0;

    #1 rst = 1'b0;
    #1;
    chk("rst_valid", 64'(a_if.valid_o), 64'h0);
    chk("rst_cnt", 64'(a_if.credit_cnt_o), 64'h4924);
    chk("rst_err", 64'(a_if.credit_err_o), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Input 0 requests output 2.
    set_req(5'b00001, 15'd2);
    #1;
    chk("t1_grant_access", 64'(a_if.grant_access_o), 64'h04);

    // Drain output 2.
    for (int k = 0; k < 4; k++) step(5'b00100, 5'b00000);
    chk("t2_cnt2_empty", 64'(a_if.credit_cnt_o[2*CW +: CW]), 64'h0);
    chk("t2_grant_dropped", 64'(a_if.grant_access_o), 64'h00);

    // Grant on empty output with simultaneous return.
    step(5'b00100, 5'b00100);
    chk("t3_cnt2_one", 64'(a_if.credit_cnt_o[2*CW +: CW]), 64'h1);
    chk("t3_err2", 64'(a_if.credit_err_o[2]), 64'h1);

    // Output 1 at two credits, consume and return together.
    set_req('0, '0);
    step(5'b00010, 5'b00000);
    step(5'b00010, 5'b00000);
    for (int k = 0; k < 3; k++) step(5'b00010, 5'b00010);
    chk("t4_cnt1_hold", 64'(a_if.credit_cnt_o[1*CW +: CW]), 64'h2);

    // Return into a full counter.
    step(5'b00000, 5'b00001);
    chk("t5_cnt0_full", 64'(a_if.credit_cnt_o[0*CW +: CW]), 64'h4);
    chk("t5_err", 64'(a_if.credit_err_o), 64'h05);

    // Reset in the middle of a transfer on output 3.
    for (int k = 0; k < 3; k++) step(5'b01000, 5'b00000);
    chk("t6_pre_valid3", 64'(a_if.valid_o[3]), 64'h1);
    a_if.granted_i = '0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("t6_async_valid", 64'(a_if.valid_o), 64'h0);
    chk("t6_async_cnt", 64'(a_if.credit_cnt_o), 64'h4924);
    chk("t6_async_err", 64'(a_if.credit_err_o), 64'h0);
    #2 rst = 1'b1;
    step(5'b00000, 5'b00000);

    // Random traffic, including out-of-range request addresses.
    for (int k = 0; k < 40; k++) begin
      set_req(5'($urandom_range(0, 31)), 15'($urandom_range(0, 32767)));
      step(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    set_req('0, '0);
    step(5'b00000, 5'b00000);

    // 8-port, depth-8 instance: input 5 requests output 7.
    b_if.req_valid_i     = 8'h20;
    b_if.req_port_addr_i = 24'd7 << 15;
    #1;
    chk("b_grant_access", 64'(b_if.grant_access_o), 64'h80);
    chk("b_rst_cnt", 64'(b_if.credit_cnt_o), 64'h88888888);
    for (int k = 0; k < 8; k++) begin
      b_if.granted_i = 8'h80;
      @(posedge clk);
      #1;
      b_exp = {4'(7 - k), 28'h8888888};
      chk("b_drain_valid", 64'(b_if.valid_o), 64'h80);
      chk("b_drain_cnt", 64'(b_if.credit_cnt_o), 64'(b_exp));
    end
    chk("b_grant_dropped", 64'(b_if.grant_access_o), 64'h00);
    b_if.credit_en_i = 8'h80;
    @(posedge clk);
    #1;
    chk("b_underflow_valid", 64'(b_if.valid_o), 64'h00);
    chk("b_underflow_cnt", 64'(b_if.credit_cnt_o), 64'h18888888);
    chk("b_underflow_err", 64'(b_if.credit_err_o), 64'h80);
    b_if.granted_i   = 8'h00;
    b_if.credit_en_i = 8'h01;
    @(posedge clk);
    #1;
    chk("b_overflow_cnt", 64'(b_if.credit_cnt_o), 64'h18888888);
    chk("b_overflow_err", 64'(b_if.credit_err_o), 64'h81);
    b_if.credit_en_i = 8'h00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
